// File: rtl/prog_loader.sv
// Byte-stream program loader: count header, 9-bit words, optional checksum.
// Define LOADER_CHECKSUM_EN to add the trailing checksum byte and load_err.
module prog_loader #(
  parameter int D = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_req,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         mem_we,
  output logic [D-1:0] mem_addr,
  output logic [8:0]   mem_wdata,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [D-1:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, W_LO, W_HI, CHK, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, W_LO, W_HI, DONE
  } state_t;
`endif

  state_t       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         mem_we_q, mem_we_d;
  logic [D-1:0] mem_addr_q, mem_addr_d;
  logic [8:0]   mem_wdata_q, mem_wdata_d;
  logic         cpu_hold_q, cpu_hold_d;
  logic         load_done_q, load_done_d;
  logic [D-1:0] words_q, words_d;
  logic [9:0]   cnt_q, cnt_d;
  logic [7:0]   lo_q, lo_d;
  logic         accept;
  logic         fin;
  logic         add_sum;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   sum_q, sum_d;
  logic         err_q, err_d;
  logic         clr_sum;
`endif

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    fin         = 1'b0;
    add_sum     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    err_d       = err_q;
    clr_sum     = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (load_req) begin
          state_d     = CNT_LO;
          words_d     = '0;
          load_done_d = 1'b0;
          cpu_hold_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          err_d       = 1'b0;
          clr_sum     = 1'b1;
`endif
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_d[7:0] = in_data;
          add_sum    = 1'b1;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_d[9:8] = in_data[1:0];
          add_sum    = 1'b1;
          if ({in_data[1:0], cnt_q[7:0]} == 10'd0)
            fin = 1'b1;
          else
            state_d = W_LO;
        end
      end
      W_LO: begin
        if (accept) begin
          lo_d    = in_data;
          add_sum = 1'b1;
          state_d = W_HI;
        end
      end
      W_HI: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = {in_data[0], lo_q};
          mem_addr_d  = words_q;
          words_d     = words_q + D'(1);
          add_sum     = 1'b1;
          if (words_q + D'(1) == D'(cnt_q))
            fin = 1'b1;
          else
            state_d = W_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          err_d       = (in_data != sum_q);
          load_done_d = 1'b1;
          cpu_hold_d  = 1'b0;
          state_d     = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Header/body complete: release the CPU unless a checksum follows
    if (fin) begin
`ifdef LOADER_CHECKSUM_EN
      state_d     = CHK;
`else
      state_d     = DONE;
      load_done_d = 1'b1;
      cpu_hold_d  = 1'b0;
`endif
    end

`ifdef LOADER_CHECKSUM_EN
    sum_d = sum_q;
    if (clr_sum)
      sum_d = 8'd0;
    else if (add_sum)
      sum_d = sum_q + in_data;
`endif

    in_ready_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      words_q     <= '0;
      cnt_q       <= '0;
      lo_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign words_loaded = words_q;
`ifdef LOADER_CHECKSUM_EN
  assign load_err     = err_q;
`else
  assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: sessions, stalls, reset abort, load_req
// ignore, and the checksum byte when LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_req;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         mem_we;
  logic [D-1:0] mem_addr;
  logic [8:0]   mem_wdata;
  logic         cpu_hold;
  logic         load_done;
  logic         load_err;
  logic [D-1:0] words_loaded;

  int errs = 0;
  int checks = 0;

  int         nwr = 0;
  logic [D-1:0] wr_addr [8];
  logic [8:0]   wr_data [8];

  prog_loader #(.D(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      if (nwr < 8) begin
        wr_addr[nwr] = mem_addr;
        wr_data[nwr] = mem_wdata;
      end
      nwr = nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic start();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   {31'd0, in_ready},  32'd0);
    chk({tag, "_we"},    {31'd0, mem_we},    32'd0);
    chk({tag, "_addr"},  {22'd0, mem_addr},  32'd0);
    chk({tag, "_wdata"}, {23'd0, mem_wdata}, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold},  32'd0);
    chk({tag, "_done"},  {31'd0, load_done}, 32'd0);
    chk({tag, "_err"},   {31'd0, load_err},  32'd0);
    chk({tag, "_words"}, {22'd0, words_loaded}, 32'd0);
  endtask

  // Two-word session 02,00,A5,01,3C,00 (+ checksum E4 when enabled).
  task automatic run_two(input string tag, input int gap, input bit poke);
    nwr = 0;
    start();
    chk({tag, "_hold1"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_wl0"}, {22'd0, words_loaded}, 32'd0);
    send(8'h02, gap);
    send(8'h00, (poke && gap == 0) ? 1 : gap);
    if (poke) begin
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
    end
    send(8'hA5, gap);
    send(8'h01, gap);
    send(8'h3C, gap);
    send(8'h00, gap);
`ifdef LOADER_CHECKSUM_EN
    send(8'hE4, gap);
`else
    if (gap == 0) begin
      chk({tag, "_lastwe"}, {31'd0, mem_we}, 32'd1);
      chk({tag, "_lastdone"}, {31'd0, load_done}, 32'd1);
    end
`endif
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, nwr, 32'd2);
    chk({tag, "_a0"}, {22'd0, wr_addr[0]}, 32'h000);
    chk({tag, "_d0"}, {23'd0, wr_data[0]}, 32'h1A5);
    chk({tag, "_a1"}, {22'd0, wr_addr[1]}, 32'h001);
    chk({tag, "_d1"}, {23'd0, wr_data[1]}, 32'h03C);
    chk({tag, "_words"}, {22'd0, words_loaded}, 32'd2);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
    chk({tag, "_hold_addr"}, {22'd0, mem_addr}, 32'h001);
    chk({tag, "_hold_data"}, {23'd0, mem_wdata}, 32'h03C);
  endtask

  initial begin
    reset    = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    do_reset();
    check_reset_vals("rst");

    run_two("b2b", 0, 1'b0);
    run_two("gap", 3, 1'b0);
    run_two("ign", 0, 1'b1);

    // Zero-length program
    nwr = 0;
    start();
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk("z_chk_rdy", {31'd0, in_ready}, 32'd1);
    send(8'h00, 0);
    in_valid = 1'b0;
    chk("z_err", {31'd0, load_err}, 32'd0);
`endif
    chk("z_done", {31'd0, load_done}, 32'd1);
    chk("z_rdy", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("z_nwr", nwr, 32'd0);
    chk("z_words", {22'd0, words_loaded}, 32'd0);

    // Reset after W_LO of word 1
    nwr = 0;
    start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h3C, 0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("abort");
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("abort_nwr", nwr, 32'd1);
    chk("abort_rdy", {31'd0, in_ready}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum of 01,00,FF,01 is 01
    nwr = 0;
    start();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h01, 0);
    send(8'h01, 0);
    in_valid = 1'b0;
    chk("ck_ok_err", {31'd0, load_err}, 32'd0);
    chk("ck_ok_done", {31'd0, load_done}, 32'd1);
    chk("ck_ok_d0", {23'd0, wr_data[0]}, 32'h1FF);
    start();
    chk("ck_clr_err", {31'd0, load_err}, 32'd0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    in_valid = 1'b0;
    chk("ck_bad_err", {31'd0, load_err}, 32'd1);
    chk("ck_bad_done", {31'd0, load_done}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: D, default 10, instruction memory address width (matches program counter width).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_req  input  1  one-cycle request to begin a load session.
REQ-005 in_valid  input  1  byte on in_data is valid.
REQ-006 in_data  input  8  serial program byte stream.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
REQ-008 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 mem_addr  output  D  instruction memory write address.
REQ-010 mem_wdata  output  9  instruction word: [8:6] opcode, [5:3] reg 1, [2:0] reg 2 or immediate.
REQ-011 cpu_hold  output  1  drives the CPU start input; holds the CPU while loading.
REQ-012 load_done  output  1  session complete; stays high until the next accepted load_req.
REQ-013 load_err  output  1  checksum mismatch flag; valid while load_done is high.
REQ-014 words_loaded  output  D  count of words written in the current or last session.

Function
REQ-015 States: IDLE, CNT_LO, CNT_HI, W_LO, W_HI, CHK, DONE.
REQ-016 IDLE/DONE: on load_req, go to CNT_LO; clear words_loaded, load_done, load_err and the checksum; set cpu_hold.
REQ-017 load_req in any other state is ignored.
REQ-018 in_ready is high only in CNT_LO, CNT_HI, W_LO, W_HI and CHK; states advance only on an accepted byte.
REQ-019 CNT_LO: accepted byte -> word_count[7:0]. CNT_HI: accepted byte bits[1:0] -> word_count[9:8]; bits[7:2] are ignored.
REQ-020 After CNT_HI: if word_count == 0, go to CHK (with macro) or DONE (without); otherwise go to W_LO.
REQ-021 W_LO: accepted byte -> instr[7:0]. W_HI: accepted byte bit0 -> instr[8]; bits[7:1] are ignored.
REQ-022 In the cycle after a W_HI accept: mem_we=1, mem_wdata=instr, mem_addr=words_loaded (pre-increment); words_loaded then increments.
REQ-023 The write cycle does not stall the stream; W_LO of the next word may accept in that same cycle.
REQ-024 After the W_HI accept that completes word_count words: go to CHK (with macro) or DONE (without).
REQ-025 Entering DONE: cpu_hold=0 and load_done=1 in the same cycle as the final mem_we pulse, or later.
REQ-026 mem_we is 0 in every cycle other than those in REQ-022.
REQ-027 mem_addr and mem_wdata hold their last values when mem_we=0.
REQ-028 Addresses run 0..word_count-1 and never wrap, since word_count is at most 1023.

Reset
REQ-029 Reset takes priority over all inputs, including mid-session.
REQ-030 Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0.
REQ-031 After reset, no write from a partially received word is ever issued.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: checksum = 8-bit modulo-256 sum of every accepted byte from CNT_LO through the last W_HI.
REQ-033 With the macro, CHK accepts one byte; load_err = (byte != checksum); then go to DONE.
REQ-034 Macro undefined: no CHK state and no checksum logic; load_err is tied to 0.

Verification
REQ-035 Bytes 02,00,A5,01,3C,00, in_valid held high -> writes addr0=0x1A5, addr1=0x03C; words_loaded=2; load_done=1; cpu_hold=0.
REQ-036 Bytes 00,00 (no macro) -> no mem_we pulses; DONE on the cycle after the CNT_HI accept.
REQ-037 Same stream as REQ-035 with in_valid low for 3 cycles between each byte -> identical writes and final outputs.
REQ-038 Reset asserted after the W_LO accept of word 1 in REQ-035 -> only the addr0 write has occurred; all outputs at reset values; state IDLE.
REQ-039 With LOADER_CHECKSUM_EN: bytes 01,00,FF,01 then 01 -> load_err=0; the same bytes then 02 -> load_err=1.
REQ-040 load_req pulsed while in W_LO -> ignored; the session completes unchanged.
